// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: every signal the sequencer exchanges with the rest of the
// core, bundled into one interface. The sequencer side uses the master modport.
//   start                       level request to leave IDLE/HALT
//   busy, halted, pc            status outputs
//   imem_req/addr/ack/rdata     instruction fetch handshake
//   rf_addr/rd_en/wr_en/wdata   register-file access
//   alu_op/operand/start        ALU launch
//   alu_done/result/flags       ALU completion
interface instr_sequencer_if #(
  parameter int PC_W = 8
);
  logic            start;
  logic            busy;
  logic            halted;
  logic [PC_W-1:0] pc;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [4:0]      rf_addr;
  logic            rf_rd_en;
  logic            rf_wr_en;
  logic [15:0]     rf_wdata;
  logic [3:0]      alu_op;
  logic [15:0]     alu_operand;
  logic            alu_start;
  logic            alu_done;
  logic [15:0]     alu_result;
  logic [3:0]      alu_flags;

  modport master (
    input  start, imem_ack, imem_rdata, alu_done, alu_result, alu_flags,
    output busy, halted, pc, imem_req, imem_addr, rf_addr, rf_rd_en, rf_wr_en,
           rf_wdata, alu_op, alu_operand, alu_start
  );

  modport slave (
    output start, imem_ack, imem_rdata, alu_done, alu_result, alu_flags,
    input  busy, halted, pc, imem_req, imem_addr, rf_addr, rf_rd_en, rf_wr_en,
           rf_wdata, alu_op, alu_operand, alu_start
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute/writeback controller.
// Fetches a 32-bit word, decodes the fixed field layout
//   imm=[31:16] rd=[15:11] rd_bit=[10] wr_bit=[9] li_bit=[8] opcode=[7:4] cond=[3:0]
// and sequences register reads/writes and ALU operations. A 4-bit flag register
// (written only by ALU completions) gates instructions with a non-zero cond.
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   bus         instr_sequencer_if master modport (handshakes and status)
module instr_sequencer #(
  parameter int          PC_W    = 8,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_sequencer_if.master     bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT_ALU, S_WB, S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [3:0]      flags_q, flags_d;
  logic [15:0]     result_q, result_d;

  logic imem_req_q, rf_rd_en_q, rf_wr_en_q, alu_start_q, busy_q, halted_q;

  logic [15:0] imm;
  logic [4:0]  rd;
  logic        rd_bit, wr_bit, li_bit;
  logic [3:0]  opcode, cond;

  assign imm    = instr_q[31:16];
  assign rd     = instr_q[15:11];
  assign rd_bit = instr_q[10];
  assign wr_bit = instr_q[9];
  assign li_bit = instr_q[8];
  assign opcode = instr_q[7:4];
  assign cond   = instr_q[3:0];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    flags_d  = flags_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Priority: halt, then condition skip, then li, then ALU, then plain WB.
        if (opcode == HALT_OP) begin
          state_d = S_HALT;
        end else if (cond != 4'd0 && (cond & flags_q) == 4'd0) begin
          state_d = S_FETCH;
        end else if (li_bit) begin
          result_d = imm;
          state_d  = S_WB;
        end else if (rd_bit) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_WB;
        end
      end
      S_EXEC: state_d = S_WAIT_ALU;
      S_WAIT_ALU: begin
        if (bus.alu_done) begin
          result_d = bus.alu_result;
          flags_d  = bus.alu_flags;
          state_d  = S_WB;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each is high exactly while
  // the FSM sits in the matching state, and the async reset clears them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      flags_q     <= '0;
      result_q    <= '0;
      imem_req_q  <= 1'b0;
      rf_rd_en_q  <= 1'b0;
      rf_wr_en_q  <= 1'b0;
      alu_start_q <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      flags_q     <= flags_d;
      result_q    <= result_d;
      imem_req_q  <= (state_d == S_FETCH);
      rf_rd_en_q  <= (state_d == S_EXEC);
      alu_start_q <= (state_d == S_EXEC);
      // WB is only entered with instr_d == instr_q, so its wr bit is final here.
      rf_wr_en_q  <= (state_d == S_WB) && instr_d[9];
      busy_q      <= (state_d != S_IDLE) && (state_d != S_HALT);
      halted_q    <= (state_d == S_HALT);
    end
  end

  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;
  assign bus.pc          = pc_q;
  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.rf_addr     = rd;
  assign bus.rf_rd_en    = rf_rd_en_q;
  assign bus.rf_wr_en    = rf_wr_en_q;
  assign bus.rf_wdata    = result_q;
  assign bus.alu_op      = opcode;
  assign bus.alu_operand = imm;
  assign bus.alu_start   = alu_start_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed and random programs run on instr_sequencer with a
// memory responder and an ALU responder; an instruction-level reference model
// walks the same program and is compared against the logged bus events.
module tb_instr_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_sequencer_if #(.PC_W(8)) bus();
  instr_sequencer #(.PC_W(8), .HALT_OP(4'hF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Narrow-PC instance used only for the wrap check: always-skip words, instant ack.
  instr_sequencer_if #(.PC_W(2)) bus2();
  instr_sequencer #(.PC_W(2), .HALT_OP(4'hF)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  assign bus2.imem_ack   = bus2.imem_req;
  assign bus2.imem_rdata = 32'h0000_0001;
  assign bus2.alu_done   = 1'b0;
  assign bus2.alu_result = 16'h0;
  assign bus2.alu_flags  = 4'h0;

  localparam logic [31:0] HALT_W = 32'h0000_00F0;

  logic [31:0] mem [256];
  int          ack_dly_fix = 0;
  int          alu_dly_fix = 0;
  bit          alu_fix     = 1'b0;
  logic [15:0] alu_res_fix = 16'h0;
  logic [3:0]  alu_flg_fix = 4'h0;

  logic [7:0]  fetch_q[$];
  int          ackcyc_q[$];
  logic [25:0] alu_q[$];   // {rd_en, rf_addr, alu_op, alu_operand}
  logic [19:0] rsp_q[$];   // {result, flags}
  logic [28:0] wr_q[$];    // {rf_addr, rf_wdata, pc}

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks after a fixed or random number of request cycles.
  int cyc = 0;
  int mcnt = 0;
  int mdly = 0;
  always @(negedge clk) begin
    cyc++;
    bus.imem_ack = 1'b0;
    if (!rst_n) begin
      mcnt = 0;
      mdly = (ack_dly_fix >= 0) ? ack_dly_fix : int'($urandom_range(0, 3));
    end else if (bus.imem_req) begin
      if (mcnt >= mdly) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem[bus.imem_addr];
        fetch_q.push_back(bus.imem_addr);
        ackcyc_q.push_back(cyc);
        mcnt = 0;
        mdly = (ack_dly_fix >= 0) ? ack_dly_fix : int'($urandom_range(0, 3));
      end else begin
        mcnt++;
      end
    end
  end

  // ALU responder and strobe monitor. A pending completion survives reset on
  // purpose so a late alu_done can reach an idle sequencer.
  bit          apend = 1'b0;
  int          acnt = 0;
  logic [15:0] ares;
  logic [3:0]  aflg;
  always @(negedge clk) begin
    bus.alu_done = 1'b0;
    if (apend) begin
      if (acnt == 0) begin
        apend = 1'b0;
        ares  = alu_fix ? alu_res_fix : 16'($urandom);
        aflg  = alu_fix ? alu_flg_fix : 4'($urandom);
        bus.alu_done   = 1'b1;
        bus.alu_result = ares;
        bus.alu_flags  = aflg;
        rsp_q.push_back({ares, aflg});
      end else begin
        acnt--;
      end
    end
    if (rst_n && bus.alu_start) begin
      apend = 1'b1;
      acnt  = (alu_dly_fix >= 0) ? alu_dly_fix : int'($urandom_range(0, 4));
      alu_q.push_back({bus.rf_rd_en, bus.rf_addr, bus.alu_op, bus.alu_operand});
    end
    if (rst_n && bus.rf_wr_en) wr_q.push_back({bus.rf_addr, bus.rf_wdata, bus.pc});
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_halt(input int lim);
    int n = 0;
    while (!bus.halted && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", bus.halted, 1'b1);
  endtask

  // Instruction-level reference: walk the program from PC 0 and compare every
  // fetch, ALU launch and register write logged since the given queue offsets.
  task automatic model_check(input int bf, input int ba, input int br, input int bw);
    logic [7:0]  mpc = 8'd0;
    logic [3:0]  mfl = 4'd0;
    logic [15:0] mres = 16'd0;
    logic [31:0] w;
    int nf = bf, na = ba, nr = br, nw = bw;
    for (int step = 0; step < 2000; step++) begin
      w = mem[mpc];
      if (nf < fetch_q.size()) chk("fetch_addr", fetch_q[nf], mpc);
      nf++;
      mpc = mpc + 8'd1;
      if (w[7:4] == 4'hF) break;
      if (w[3:0] != 4'd0 && (w[3:0] & mfl) == 4'd0) continue;
      if (w[8]) begin
        mres = w[31:16];
      end else if (w[10]) begin
        if (na < alu_q.size()) chk("alu_launch", alu_q[na], {1'b1, w[15:11], w[7:4], w[31:16]});
        na++;
        if (nr < rsp_q.size()) {mres, mfl} = rsp_q[nr];
        nr++;
      end
      if (w[9]) begin
        if (nw < wr_q.size()) chk("rf_write", wr_q[nw], {w[15:11], mres, mpc});
        nw++;
      end
    end
    chk("fetch_count", fetch_q.size(), nf);
    chk("alu_count", alu_q.size(), na);
    chk("wr_count", wr_q.size(), nw);
    chk("final_pc", bus.pc, mpc);
  endtask

  initial begin
    int bf, ba, br, bw, n;
    logic [31:0] w;
    logic [1:0]  wrap_addr [5];
    logic [1:0]  wrap_exp  [5];
    bus.start  = 1'b0;
    bus2.start = 1'b0;

    // Reset state
    do_reset();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_halted", bus.halted, 1'b0);
    chk("rst_pc", bus.pc, 8'd0);
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_wr", bus.rf_wr_en, 1'b0);
    chk("rst_rd", bus.rf_rd_en, 1'b0);
    chk("rst_alu", bus.alu_start, 1'b0);

    // li with ack delayed 2 cycles
    for (int i = 0; i < 256; i++) mem[i] = HALT_W;
    mem[0] = 32'h00AB_0B00;
    ack_dly_fix = 2; alu_dly_fix = 0;
    do_reset();
    bf = fetch_q.size(); ba = alu_q.size(); br = rsp_q.size(); bw = wr_q.size();
    start_run();
    wait_halt(200);
    chk("t1_wr_n", wr_q.size() - bw, 1);
    if (wr_q.size() > bw) chk("t1_wr", wr_q[bw], {5'd1, 16'h00AB, 8'd1});
    chk("t1_alu_n", alu_q.size() - ba, 0);
    model_check(bf, ba, br, bw);

    // ALU op (rd=2, rd_bit, wr_bit, op=3), then cond miss and cond hit
    for (int i = 0; i < 256; i++) mem[i] = HALT_W;
    mem[0] = 32'h0005_1630;
    mem[1] = 32'h0077_0B08;
    mem[2] = 32'h0066_0B04;
    ack_dly_fix = 0; alu_dly_fix = 3;
    alu_fix = 1'b1; alu_res_fix = 16'h1234; alu_flg_fix = 4'b0100;
    do_reset();
    bf = fetch_q.size(); ba = alu_q.size(); br = rsp_q.size(); bw = wr_q.size();
    start_run();
    wait_halt(200);
    chk("t2_wr_n", wr_q.size() - bw, 2);
    if (wr_q.size() > bw + 1) begin
      chk("t2_alu_wr", wr_q[bw], {5'd2, 16'h1234, 8'd1});
      chk("t3_cond_wr", wr_q[bw+1], {5'd1, 16'h0066, 8'd3});
    end
    if (ackcyc_q.size() > bf + 3) begin
      chk("t2_alu_lat", ackcyc_q[bf+1] - ackcyc_q[bf], 8);
      chk("t3_skip_lat", ackcyc_q[bf+2] - ackcyc_q[bf+1], 2);
      chk("t3_li_lat", ackcyc_q[bf+3] - ackcyc_q[bf+2], 3);
    end
    model_check(bf, ba, br, bw);
    alu_fix = 1'b0;

    // Halt with wr and li set, then restart from HALT
    for (int i = 0; i < 256; i++) mem[i] = HALT_W;
    mem[0] = 32'h1234_0BF0;
    do_reset();
    bf = fetch_q.size(); bw = wr_q.size();
    start_run();
    wait_halt(200);
    chk("t4_no_wr", wr_q.size() - bw, 0);
    chk("t4_busy", bus.busy, 1'b0);
    chk("t4_pc", bus.pc, 8'd1);
    start_run();
    wait_halt(200);
    if (fetch_q.size() > bf + 1) chk("t4_refetch_addr", fetch_q[bf+1], 8'd0);
    chk("t4_refetch_n", fetch_q.size() - bf, 2);
    chk("t4_pc2", bus.pc, 8'd1);

    // Random programs against the reference model
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) begin
        w = $urandom;
        if (w[7:4] == 4'hF && $urandom_range(0, 19) != 0) w[7:4] = 4'h0;
        if ($urandom_range(0, 1) == 0) w[3:0] = 4'h0;
        mem[i] = w;
      end
      mem[$urandom_range(8, 40)] = HALT_W;
      ack_dly_fix = -1; alu_dly_fix = -1;
      do_reset();
      bf = fetch_q.size(); ba = alu_q.size(); br = rsp_q.size(); bw = wr_q.size();
      start_run();
      wait_halt(5000);
      model_check(bf, ba, br, bw);
    end

    // PC wrap on the 2-bit instance
    do_reset();
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      if (bus2.imem_req) begin
        wrap_addr[n] = bus2.imem_addr;
        n++;
      end
      @(negedge clk);
    end
    chk("t5_fetch_n", n, 5);
    wrap_exp[0] = 2'd0; wrap_exp[1] = 2'd1; wrap_exp[2] = 2'd2;
    wrap_exp[3] = 2'd3; wrap_exp[4] = 2'd0;
    for (int i = 0; i < n; i++) chk("t5_wrap_addr", wrap_addr[i], wrap_exp[i]);

    // Reset while waiting on the ALU; the late alu_done must be ignored
    for (int i = 0; i < 256; i++) mem[i] = HALT_W;
    mem[0] = 32'h0005_1630;
    ack_dly_fix = 0; alu_dly_fix = 10;
    do_reset();
    ba = alu_q.size(); br = rsp_q.size(); bw = wr_q.size();
    start_run();
    n = 0;
    while (alu_q.size() == ba && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_alu_started", alu_q.size() - ba, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_wr", bus.rf_wr_en, 1'b0);
    chk("t6_req", bus.imem_req, 1'b0);
    chk("t6_alu", bus.alu_start, 1'b0);
    chk("t6_pc", bus.pc, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("t6_late_done", rsp_q.size() - br, 1);
    chk("t6_no_wr", wr_q.size() - bw, 0);
    chk("t6_idle_busy", bus.busy, 1'b0);
    chk("t6_idle_halted", bus.halted, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
